// File: rtl/lc3_control_fsm.sv
// Multi-cycle LC-3 control unit: sequences fetch, decode and execute over a
// datapath with a registered bus. RTI, LDI, STI and opcode 1101 halt as illegal.
module lc3_control_fsm #(
  parameter int unsigned MEM_WAIT_MAX = 255,
  parameter logic [7:0]  HALT_VECTOR  = 8'h25
) (
  input  logic        i_Clk,
  input  logic        reset,
  input  logic [15:0] ir,
  input  logic        R,
  input  logic [2:0]  nzp,
  output logic        SR2MUX_SEL,
  output logic        ADDR1MUX_SEL,
  output logic        MARMUX_SEL,
  output logic        MIO_EN,
  output logic        RW,
  output logic        LD_REG,
  output logic        LD_CC,
  output logic        LD_IR,
  output logic        LD_PC,
  output logic        LD_MAR,
  output logic        LD_MDR,
  output logic        LD_BUS,
  output logic [1:0]  ADDR2MUX_SEL,
  output logic [1:0]  PCMUX_SEL,
  output logic [1:0]  BUS_SEL,
  output logic [1:0]  ALUK,
  output logic [2:0]  DR,
  output logic [2:0]  SR1_SEL,
  output logic [2:0]  SR2_SEL,
  output logic        o_halted,
  output logic        o_illegal,
  output logic        o_mem_err,
  output logic [4:0]  o_state
);

  typedef enum logic [4:0] {
    S_FETCH0    = 5'd0,  S_FETCH1    = 5'd1,  S_FETCH_RD  = 5'd2,  S_FETCH_DRV = 5'd3,
    S_FETCH_LDIR= 5'd4,  S_DECODE    = 5'd5,  S_ALU_DRV   = 5'd6,  S_ALU_LD    = 5'd7,
    S_LEA_DRV   = 5'd8,  S_LEA_LD    = 5'd9,  S_BR        = 5'd10, S_JMP       = 5'd11,
    S_JSR_DRV   = 5'd12, S_JSR_LD    = 5'd13, S_MEM_ADDR  = 5'd14, S_MEM_MAR   = 5'd15,
    S_LD_RD     = 5'd16, S_LD_DRV    = 5'd17, S_LD_LD     = 5'd18, S_ST_DRV    = 5'd19,
    S_ST_MDR    = 5'd20, S_ST_WR     = 5'd21, S_TRAP_DRV  = 5'd22, S_TRAP_R7   = 5'd23,
    S_TRAP_ADDR = 5'd24, S_TRAP_MAR  = 5'd25, S_TRAP_RD   = 5'd26, S_TRAP_PDRV = 5'd27,
    S_TRAP_PC   = 5'd28, S_HALT      = 5'd29
  } state_t;

  localparam logic [3:0] OP_BR  = 4'h0, OP_ADD = 4'h1, OP_LD  = 4'h2, OP_ST  = 4'h3,
                         OP_JSR = 4'h4, OP_AND = 4'h5, OP_LDR = 4'h6, OP_STR = 4'h7,
                         OP_NOT = 4'h9, OP_JMP = 4'hC, OP_LEA = 4'hE, OP_TRAP = 4'hF;

  state_t      state, state_n;
  logic [15:0] wait_cnt;
  logic        set_illegal, set_mem_err;
  logic        mem_state, mem_timeout;
  logic [3:0]  opcode;
  logic [1:0]  alu_k;

  assign opcode  = ir[15:12];
  assign o_state = state;
  assign alu_k   = (opcode == OP_ADD) ? 2'd0 : (opcode == OP_AND) ? 2'd1 : 2'd2;

  assign mem_state   = (state == S_FETCH_RD) || (state == S_LD_RD) ||
                       (state == S_TRAP_RD)  || (state == S_ST_WR);
  assign mem_timeout = (MEM_WAIT_MAX != 0) && mem_state && !R &&
                       ((wait_cnt + 16'd1) == 16'(MEM_WAIT_MAX));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the async reset sits in the sensitivity list.
  always_ff @(posedge i_Clk or posedge reset) begin
    if (reset) begin
      state     <= S_FETCH0;
      wait_cnt  <= '0;
      o_halted  <= 1'b0;
      o_illegal <= 1'b0;
      o_mem_err <= 1'b0;
    end else begin
      state    <= state_n;
      wait_cnt <= mem_state ? wait_cnt + 16'd1 : 16'd0;
      if (state_n == S_HALT) o_halted  <= 1'b1;
      if (set_illegal)       o_illegal <= 1'b1;
      if (set_mem_err)       o_mem_err <= 1'b1;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_n     = state;
    set_illegal = 1'b0;
    set_mem_err = 1'b0;
    case (state)
      S_FETCH0:     state_n = S_FETCH1;
      S_FETCH1:     state_n = S_FETCH_RD;
      S_FETCH_RD:   state_n = S_FETCH_DRV;
      S_FETCH_DRV:  state_n = S_FETCH_LDIR;
      S_FETCH_LDIR: state_n = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_ADD, OP_AND, OP_NOT:     state_n = S_ALU_DRV;
          OP_LEA:                     state_n = S_LEA_DRV;
          OP_BR:                      state_n = |(ir[11:9] & nzp) ? S_BR : S_FETCH0;
          OP_JMP:                     state_n = S_JMP;
          OP_JSR:                     state_n = S_JSR_DRV;
          OP_LD, OP_LDR, OP_ST, OP_STR: state_n = S_MEM_ADDR;
          OP_TRAP: state_n = (ir[7:0] == HALT_VECTOR) ? S_HALT : S_TRAP_DRV;
          default: begin
            // RTI, LDI, STI and the reserved opcode
            state_n     = S_HALT;
            set_illegal = 1'b1;
          end
        endcase
      end
      S_ALU_DRV:   state_n = S_ALU_LD;
      S_LEA_DRV:   state_n = S_LEA_LD;
      S_JSR_DRV:   state_n = S_JSR_LD;
      S_MEM_ADDR:  state_n = S_MEM_MAR;
      S_MEM_MAR:   state_n = ir[12] ? S_ST_DRV : S_LD_RD;
      S_LD_RD:     state_n = S_LD_DRV;
      S_LD_DRV:    state_n = S_LD_LD;
      S_ST_DRV:    state_n = S_ST_MDR;
      S_ST_MDR:    state_n = S_ST_WR;
      S_TRAP_DRV:  state_n = S_TRAP_R7;
      S_TRAP_R7:   state_n = S_TRAP_ADDR;
      S_TRAP_ADDR: state_n = S_TRAP_MAR;
      S_TRAP_MAR:  state_n = S_TRAP_RD;
      S_TRAP_RD:   state_n = S_TRAP_PDRV;
      S_TRAP_PDRV: state_n = S_TRAP_PC;
      S_HALT:      state_n = S_HALT;
      default:     state_n = S_FETCH0;
    endcase
    // Memory states advance only on R; otherwise hold or time out.
    if (mem_state && !R) begin
      state_n     = mem_timeout ? S_HALT : state;
      set_mem_err = mem_timeout;
    end
  end

  always_comb begin
    SR2MUX_SEL = 1'b0; ADDR1MUX_SEL = 1'b0; MARMUX_SEL = 1'b0;
    MIO_EN = 1'b0; RW = 1'b0; LD_REG = 1'b0; LD_CC = 1'b0; LD_IR = 1'b0;
    LD_PC = 1'b0; LD_MAR = 1'b0; LD_MDR = 1'b0; LD_BUS = 1'b0;
    ADDR2MUX_SEL = 2'd0; PCMUX_SEL = 2'd0; BUS_SEL = 2'd0; ALUK = 2'd0;
    DR = 3'd0; SR1_SEL = 3'd0; SR2_SEL = 3'd0;
    if (!reset) begin
      case (state)
        S_FETCH0, S_FETCH1: begin
          MARMUX_SEL = 1'b1; ADDR1MUX_SEL = 1'b1; ADDR2MUX_SEL = 2'd3;
          LD_BUS = (state == S_FETCH0);
          LD_PC  = (state == S_FETCH0);
          PCMUX_SEL = 2'd2;
          LD_MAR = (state == S_FETCH1);
        end
        S_FETCH_RD, S_LD_RD, S_TRAP_RD: begin
          MIO_EN = 1'b1;
          LD_MDR = R;
        end
        S_FETCH_DRV, S_LD_DRV, S_TRAP_PDRV: begin
          BUS_SEL = 2'd3; LD_BUS = 1'b1;
        end
        S_FETCH_LDIR: begin
          BUS_SEL = 2'd3; LD_IR = 1'b1;
        end
        S_ALU_DRV, S_ALU_LD: begin
          BUS_SEL = 2'd2; ALUK = alu_k;
          SR1_SEL = ir[8:6]; SR2_SEL = ir[2:0]; SR2MUX_SEL = ~ir[5];
          LD_BUS = (state == S_ALU_DRV);
          LD_REG = (state == S_ALU_LD); LD_CC = (state == S_ALU_LD); DR = ir[11:9];
        end
        S_LEA_DRV, S_LEA_LD: begin
          MARMUX_SEL = 1'b1; ADDR1MUX_SEL = 1'b1; ADDR2MUX_SEL = 2'd1;
          LD_BUS = (state == S_LEA_DRV);
          LD_REG = (state == S_LEA_LD); LD_CC = (state == S_LEA_LD); DR = ir[11:9];
        end
        S_BR: begin
          LD_PC = 1'b1; PCMUX_SEL = 2'd1; ADDR1MUX_SEL = 1'b1; ADDR2MUX_SEL = 2'd1;
        end
        S_JMP: begin
          LD_PC = 1'b1; PCMUX_SEL = 2'd1; ADDR2MUX_SEL = 2'd3; SR1_SEL = ir[8:6];
        end
        S_JSR_DRV, S_TRAP_DRV: begin
          BUS_SEL = 2'd1; LD_BUS = 1'b1;
        end
        S_JSR_LD: begin
          // R7 and PC load together, so JSRR reads the old base register.
          BUS_SEL = 2'd1; LD_REG = 1'b1; DR = 3'd7;
          LD_PC = 1'b1; PCMUX_SEL = 2'd1; SR1_SEL = ir[8:6];
          ADDR1MUX_SEL = ir[11];
          ADDR2MUX_SEL = ir[11] ? 2'd0 : 2'd3;
        end
        S_MEM_ADDR, S_MEM_MAR: begin
          MARMUX_SEL = 1'b1; SR1_SEL = ir[8:6];
          ADDR1MUX_SEL = ~ir[14];
          ADDR2MUX_SEL = ir[14] ? 2'd2 : 2'd1;
          LD_BUS = (state == S_MEM_ADDR);
          LD_MAR = (state == S_MEM_MAR);
        end
        S_LD_LD: begin
          BUS_SEL = 2'd3; LD_REG = 1'b1; LD_CC = 1'b1; DR = ir[11:9];
        end
        S_ST_DRV, S_ST_MDR: begin
          SR1_SEL = ir[11:9]; ALUK = 2'd3; BUS_SEL = 2'd2;
          LD_BUS = (state == S_ST_DRV);
          LD_MDR = (state == S_ST_MDR);
        end
        S_ST_WR: begin
          MIO_EN = 1'b1; RW = 1'b1;
        end
        S_TRAP_R7: begin
          BUS_SEL = 2'd1; LD_REG = 1'b1; DR = 3'd7;
        end
        S_TRAP_ADDR: LD_BUS = 1'b1;
        S_TRAP_MAR:  LD_MAR = 1'b1;
        S_TRAP_PC: begin
          BUS_SEL = 2'd3; LD_PC = 1'b1; PCMUX_SEL = 2'd0;
        end
        default: ;
      endcase
    end
  end

endmodule
